// File: rtl/key_conditioner_pkg.sv
// Shared types for the key_conditioner slice: per-channel output modes, debounce FSM states,
// and the mode-select helper used by the top-level output mux.
package key_pkg;

  typedef enum logic [1:0] {
    KM_LEVEL   = 2'b00,
    KM_PRESS   = 2'b01,
    KM_TOGGLE  = 2'b10,
    KM_RELEASE = 2'b11
  } key_mode_e;

  typedef enum logic [1:0] {
    KS_RELEASED,
    KS_PRESS_WAIT,
    KS_PRESSED,
    KS_RELEASE_WAIT
  } key_state_e;

  function automatic logic key_mode_sel(input key_mode_e m, input logic level, input logic press,
                                        input logic toggle, input logic rel);
    key_mode_sel = level;
    case (m)
      KM_LEVEL:   key_mode_sel = level;
      KM_PRESS:   key_mode_sel = press;
      KM_TOGGLE:  key_mode_sel = toggle;
      KM_RELEASE: key_mode_sel = rel;
      default:    key_mode_sel = level;
    endcase
  endfunction

endpackage

// File: rtl/key_conditioner_debounce_ch.sv
// One key channel: input synchroniser, four-state debounce FSM, press/release pulses.
// With KEY_COND_LONGPRESS_EN defined, also a saturating hold counter and a one-shot long pulse.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1
`ifdef KEY_COND_LONGPRESS_EN
  ,
  parameter int LONG_CYCLES     = 1000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic level_d,
  output logic press_d,
  output logic rel_d,
  output logic level_q,
  output logic press_q,
  output logic rel_q
`ifdef KEY_COND_LONGPRESS_EN
  ,
  output logic long_q
`endif
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  // The first accepted sample is taken on the RELEASED/PRESSED exit, so the wait states count D-1 more.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic             REL_LVL  = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  key_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   p;

  assign p = sync_q[SYNC_STAGES-1] ^ REL_LVL;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    sync_d  = {sync_q[SYNC_STAGES-2:0], key_in};
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      KS_RELEASED: begin
        if (p) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = KS_PRESSED;
            press_d = 1'b1;
          end else begin
            state_d = KS_PRESS_WAIT;
            cnt_d   = '0;
          end
        end
      end
      KS_PRESS_WAIT: begin
        if (!p) begin
          state_d = KS_RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = KS_PRESSED;
          press_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      KS_PRESSED: begin
        if (!p) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = KS_RELEASED;
            rel_d   = 1'b1;
          end else begin
            state_d = KS_RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
      end
      KS_RELEASE_WAIT: begin
        if (p) begin
          state_d = KS_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = KS_RELEASED;
          rel_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = KS_RELEASED;
    endcase
    level_d = (state_d == KS_PRESSED) || (state_d == KS_RELEASE_WAIT);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (reset) begin
      sync_q  <= {SYNC_STAGES{REL_LVL}};
      state_q <= KS_RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

`ifdef KEY_COND_LONGPRESS_EN
  localparam int               HOLD_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_HIT = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_d;

  // Hold restarts from zero on every entry to PRESSED and stops at LONG_CYCLES, so it fires once.
  always_comb begin
    hold_d = '0;
    long_d = 1'b0;
    if (state_q == KS_PRESSED && state_d == KS_PRESSED) begin
      hold_d = hold_q;
      if (hold_q == HOLD_HIT) long_d = 1'b1;
      if (hold_q != HOLD_SAT) hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end
`endif

endmodule

// File: rtl/key_conditioner.sv
// N-channel pushbutton front end: per-channel debounce, toggle registers and a registered mode mux.
// Define KEY_COND_LONGPRESS_EN to add the key_long port and per-channel hold counters.
module key_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int LONG_CYCLES     = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_KEYS-1:0]   key_in,
  input  logic [2*NUM_KEYS-1:0] mode,
  output logic [NUM_KEYS-1:0]   key_level,
  output logic [NUM_KEYS-1:0]   key_press,
  output logic [NUM_KEYS-1:0]   key_release,
`ifdef KEY_COND_LONGPRESS_EN
  output logic [NUM_KEYS-1:0]   key_long,
`endif
  output logic [NUM_KEYS-1:0]   key_out
);

  if (NUM_KEYS < 1) begin : g_chk_keys
    $error("key_conditioner: NUM_KEYS must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
    $error("key_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("key_conditioner: SYNC_STAGES must be >= 2");
  end
  if (LONG_CYCLES < 1) begin : g_chk_long_pos
    $error("key_conditioner: LONG_CYCLES must be >= 1");
  end
`ifdef KEY_COND_LONGPRESS_EN
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_chk_long
    $error("key_conditioner: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end
`endif

  logic [NUM_KEYS-1:0] lvl_d, prs_d, rel_d;
  logic [NUM_KEYS-1:0] toggle_q, toggle_d;
  logic [NUM_KEYS-1:0] key_out_q, key_out_d;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES),
      .ACTIVE_LOW     (ACTIVE_LOW)
`ifdef KEY_COND_LONGPRESS_EN
      ,
      .LONG_CYCLES    (LONG_CYCLES)
`endif
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .key_in (key_in[i]),
      .level_d(lvl_d[i]),
      .press_d(prs_d[i]),
      .rel_d  (rel_d[i]),
      .level_q(key_level[i]),
      .press_q(key_press[i]),
      .rel_q  (key_release[i])
`ifdef KEY_COND_LONGPRESS_EN
      ,
      .long_q (key_long[i])
`endif
    );
  end

  // Mux on the channels' next-state values so key_out lines up with key_level/key_press/key_release.
  always_comb begin
    toggle_d  = toggle_q ^ prs_d;
    key_out_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_out_d[i] = key_mode_sel(key_mode_e'(mode[2*i +: 2]), lvl_d[i], prs_d[i],
                                  toggle_d[i], rel_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_q  <= '0;
      key_out_q <= '0;
    end else begin
      toggle_q  <= toggle_d;
      key_out_q <= key_out_d;
    end
  end

  assign key_out = key_out_q;

endmodule
